// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   - 5-bit opcode encoding used by alu_seq
//   - bit positions of the {Z,N,C,O} flag vector
//   - FSM state enumeration of alu_seq
// Opcodes 0x15..0x1F are unassigned and behave like NOP.
package alu_pkg;

  // Single-cycle operations (complete in EXEC)
  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_ADD    = 5'h01;
  localparam logic [4:0] OP_SUB    = 5'h02;
  localparam logic [4:0] OP_AND    = 5'h03;
  localparam logic [4:0] OP_OR     = 5'h04;
  localparam logic [4:0] OP_XOR    = 5'h05;
  localparam logic [4:0] OP_NOT    = 5'h06;
  localparam logic [4:0] OP_INC    = 5'h07;
  localparam logic [4:0] OP_DEC    = 5'h08;
  localparam logic [4:0] OP_LSL    = 5'h09;  // logical shift left
  localparam logic [4:0] OP_LSR    = 5'h0A;  // logical shift right
  localparam logic [4:0] OP_RSL    = 5'h0B;  // rotate left
  localparam logic [4:0] OP_RSR    = 5'h0C;  // rotate right
  localparam logic [4:0] OP_MODULE = 5'h0D;  // magnitude |A| (two's complement)
  localparam logic [4:0] OP_CMP    = 5'h0E;
  localparam logic [4:0] OP_TST    = 5'h0F;

  // Iterative / special operations
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_DIV    = 5'h11;
  localparam logic [4:0] OP_MOD    = 5'h12;
  localparam logic [4:0] OP_LOG2   = 5'h13;
  localparam logic [4:0] OP_FACTRL = 5'h14;

  // Flag vector bit positions: flags = {Z,N,C,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_divu.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             load dividend/divisor and begin (divisor must be non-zero)
//   dividend, divisor WIDTH-bit unsigned operands
//   done              high during the WIDTH-th (final) step cycle
//   quotient,
//   remainder         result of the step being taken this cycle; final values
//                     are valid while done=1, so the parent can capture them
//                     on the same edge that completes the division
module alu_divu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             run_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  always_comb begin
    shifted = {rem_reg, quo_reg[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_reg};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo_reg[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = run_reg && (cnt_reg == CW'(1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg <= '0;
      quo_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      rem_reg <= '0;
      quo_reg <= dividend;
      dvs_reg <= divisor;
      cnt_reg <= CW'(WIDTH);
      run_reg <= 1'b1;
    end else if (run_reg) begin
      rem_reg <= rem_next;
      quo_reg <= quo_next;
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == CW'(1)) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with single-cycle and iterative operations.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      launch request, sampled only in IDLE
//   opcode     operation (see alu_pkg)
//   A, B       WIDTH-bit operands
//   busy       high in EXEC and ITER
//   done       one-cycle pulse in DONE; Result/flags are valid
//   Result     registered result, held between operations
//   flags      {Z,N,C,O}
// Every operation spends one EXEC cycle after acceptance. Single-cycle
// operations finish there; MUL, DIV/MOD (non-zero divisor) and FACTRL
// (valid, non-zero A) use EXEC to load their iteration state and then run
// their ITER cycles. Outputs are decoded from registers only.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FACT_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       flags
);

  localparam int W2    = 2 * WIDTH;
  localparam int MAXV  = (WIDTH > FACT_MAX) ? WIDTH : FACT_MAX;
  localparam int ITW   = $clog2(MAXV + 2);
  localparam logic [31:0] WIDTH_U = 32'(WIDTH);

  state_t           state;
  logic [4:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;

  logic [W2-1:0]    prod_reg;
  logic [WIDTH-1:0] fact_acc;
  logic [ITW-1:0]   fact_i;
  logic             fact_ovf;
  logic [ITW-1:0]   iter_cnt;

  // Shared single-cycle datapath
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [31:0]      shamt;
  logic [WIDTH-1:0] log2_idx;
  logic [WIDTH-1:0] exec_val;
  logic             exec_c;
  logic             exec_o;
  logic             exec_upd;
  logic             exec_keep;

  // Iterative datapath
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    prod_next;
  logic [W2-1:0]    fact_full;
  logic             fact_ovf_next;
  logic             fact_bad;

  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] v,
                                            input logic c, input logic o);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (v == '0);
    f[FLAG_N] = v[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_O] = o;
    return f;
  endfunction

  assign busy   = (state == ST_EXEC) || (state == ST_ITER);
  assign done   = (state == ST_DONE);
  assign Result = result_reg;
  assign flags  = flags_reg;

  // C is the WIDTH+1 bit of the sum; for SUB it is the borrow (A < B unsigned).
  assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
  assign sub_diff = {1'b0, op_a} - {1'b0, op_b};
  assign add_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != op_a[WIDTH-1]);
  assign sub_ovf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != op_a[WIDTH-1]);
  assign shamt    = 32'(op_b) % WIDTH_U;

  always_comb begin
    log2_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (op_a[i]) begin
        log2_idx = WIDTH'(i);
      end
    end
  end

  always_comb begin
    exec_val  = '0;
    exec_c    = 1'b0;
    exec_o    = 1'b0;
    exec_upd  = 1'b1;
    exec_keep = 1'b0;
    case (op_code)
      OP_ADD: begin
        exec_val = add_sum[WIDTH-1:0];
        exec_c   = add_sum[WIDTH];
        exec_o   = add_ovf;
      end
      OP_SUB: begin
        exec_val = sub_diff[WIDTH-1:0];
        exec_c   = sub_diff[WIDTH];
        exec_o   = sub_ovf;
      end
      OP_CMP: begin
        exec_val  = sub_diff[WIDTH-1:0];
        exec_c    = sub_diff[WIDTH];
        exec_o    = sub_ovf;
        exec_keep = 1'b1;
      end
      OP_TST: begin
        exec_val  = op_a & op_b;
        exec_keep = 1'b1;
      end
      OP_AND:    exec_val = op_a & op_b;
      OP_OR:     exec_val = op_a | op_b;
      OP_XOR:    exec_val = op_a ^ op_b;
      OP_NOT:    exec_val = ~op_a;
      OP_INC:    exec_val = op_a + 1'b1;
      OP_DEC:    exec_val = op_a - 1'b1;
      OP_LSL:    exec_val = op_a << shamt;
      OP_LSR:    exec_val = op_a >> shamt;
      // With shamt = 0 the complementary shift is by WIDTH and yields 0.
      OP_RSL:    exec_val = (op_a << shamt) | (op_a >> (WIDTH_U - shamt));
      OP_RSR:    exec_val = (op_a >> shamt) | (op_a << (WIDTH_U - shamt));
      OP_MODULE: exec_val = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
      OP_LOG2: begin
        if ((op_a == '0) || op_a[WIDTH-1]) begin
          exec_val = '1;
          exec_o   = 1'b1;
        end else begin
          exec_val = log2_idx;
        end
      end
      default:   exec_upd = 1'b0;  // NOP and unassigned opcodes
    endcase
  end

  // Shift-add multiply: low half holds the remaining multiplier bits, high
  // half accumulates; each step adds the multiplicand and shifts right.
  assign mul_sum   = {1'b0, prod_reg[W2-1:WIDTH]} +
                     (prod_reg[0] ? {1'b0, op_a} : '0);
  assign prod_next = {mul_sum, prod_reg[WIDTH-1:1]};

  assign fact_full     = W2'(fact_acc) * W2'(fact_i);
  assign fact_ovf_next = fact_ovf | (|fact_full[W2-1:WIDTH]);
  assign fact_bad      = op_a[WIDTH-1] || (32'(op_a) > 32'(FACT_MAX));

  assign div_start = (state == ST_EXEC) && is_div_op(op_code) && (op_b != '0);

  alu_divu #(
    .WIDTH(WIDTH)
  ) u_divu (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (op_a),
    .divisor  (op_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_code    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      prod_reg   <= '0;
      fact_acc   <= '0;
      fact_i     <= '0;
      fact_ovf   <= 1'b0;
      iter_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_code <= opcode;
            op_a    <= A;
            op_b    <= B;
            state   <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          case (op_code)
            OP_MUL: begin
              prod_reg <= {{WIDTH{1'b0}}, op_b};
              iter_cnt <= ITW'(WIDTH);
              state    <= ST_ITER;
            end
            OP_DIV, OP_MOD: begin
              if (op_b == '0) begin
                result_reg <= '1;
                flags_reg  <= make_flags('1, 1'b0, 1'b1);
                state      <= ST_DONE;
              end else begin
                state <= ST_ITER;  // divider loads on this edge
              end
            end
            OP_FACTRL: begin
              if (fact_bad) begin
                result_reg <= '1;
                flags_reg  <= make_flags('1, 1'b0, 1'b1);
                state      <= ST_DONE;
              end else if (op_a == '0) begin
                result_reg <= WIDTH'(1);
                flags_reg  <= make_flags(WIDTH'(1), 1'b0, 1'b0);
                state      <= ST_DONE;
              end else begin
                fact_acc <= WIDTH'(1);
                fact_i   <= ITW'(1);
                fact_ovf <= 1'b0;
                iter_cnt <= ITW'(op_a);
                state    <= ST_ITER;
              end
            end
            default: begin
              if (exec_upd) begin
                if (!exec_keep) begin
                  result_reg <= exec_val;
                end
                flags_reg <= make_flags(exec_val, exec_c, exec_o);
              end
              state <= ST_DONE;
            end
          endcase
        end

        ST_ITER: begin
          case (op_code)
            OP_MUL: begin
              prod_reg <= prod_next;
              iter_cnt <= iter_cnt - 1'b1;
              if (iter_cnt == ITW'(1)) begin
                result_reg <= prod_next[WIDTH-1:0];
                flags_reg  <= make_flags(prod_next[WIDTH-1:0], 1'b0,
                                         |prod_next[W2-1:WIDTH]);
                state      <= ST_DONE;
              end
            end
            OP_DIV, OP_MOD: begin
              if (div_done) begin
                if (op_code == OP_DIV) begin
                  result_reg <= div_quo;
                  flags_reg  <= make_flags(div_quo, 1'b0, 1'b0);
                end else begin
                  result_reg <= div_rem;
                  flags_reg  <= make_flags(div_rem, 1'b0, 1'b0);
                end
                state <= ST_DONE;
              end
            end
            OP_FACTRL: begin
              fact_acc <= fact_full[WIDTH-1:0];
              fact_ovf <= fact_ovf_next;
              fact_i   <= fact_i + 1'b1;
              iter_cnt <= iter_cnt - 1'b1;
              if (iter_cnt == ITW'(1)) begin
                result_reg <= fact_full[WIDTH-1:0];
                flags_reg  <= make_flags(fact_full[WIDTH-1:0], 1'b0,
                                         fact_ovf_next);
                state      <= ST_DONE;
              end
            end
            default: state <= ST_DONE;
          endcase
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 16-bit and a 32-bit instance are driven
// with directed vectors and random operations, each compared against a
// behavioural arithmetic model (results, flags and latency).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int FMAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start16, busy16, done16;
  logic [4:0]  opcode16;
  logic [15:0] a16, b16, res16;
  logic [3:0]  flags16;

  logic        start32, busy32, done32;
  logic [4:0]  opcode32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  flags32;

  alu_seq #(.WIDTH(16), .FACT_MAX(FMAX)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .opcode(opcode16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .Result(res16), .flags(flags16));

  alu_seq #(.WIDTH(32), .FACT_MAX(FMAX)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .opcode(opcode32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .Result(res32), .flags(flags32));

  int n_checks = 0;
  int n_errors = 0;
  int n_trans  = 0;
  logic [63:0] exp_res [2];
  logic [3:0]  exp_flg [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Behavioural reference: plain arithmetic on 64-bit values.
  task automatic model(input int w, input logic [4:0] op, input logic [63:0] a, b,
                       input logic [63:0] pres, input logic [3:0] pflg,
                       output logic [63:0] res, output logic [3:0] flg, output int lat);
    logic [63:0] mask, msb, v, p;
    longint sa, sb, sr;
    logic c, o, nop, keep;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    msb  = 64'd1 << (w - 1);
    sa   = (a >= msb) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = (b >= msb) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    sh   = int'(b % 64'(w));
    v = 0; c = 0; o = 0; nop = 0; keep = 0; lat = 2;
    case (op)
      OP_ADD: begin
        v = (a + b) & mask; c = ((a + b) >> w) != 0; sr = sa + sb;
        o = (sr > longint'(msb) - 1) || (sr < -longint'(msb));
      end
      OP_SUB, OP_CMP: begin
        v = (a - b) & mask; c = (a < b); sr = sa - sb;
        o = (sr > longint'(msb) - 1) || (sr < -longint'(msb));
        keep = (op == OP_CMP);
      end
      OP_TST:    begin v = a & b; keep = 1; end
      OP_AND:    v = a & b;
      OP_OR:     v = a | b;
      OP_XOR:    v = a ^ b;
      OP_NOT:    v = ~a & mask;
      OP_INC:    v = (a + 1) & mask;
      OP_DEC:    v = (a - 1) & mask;
      OP_LSL:    v = (a << sh) & mask;
      OP_LSR:    v = a >> sh;
      OP_RSL:    v = ((a << sh) | (a >> (w - sh))) & mask;
      OP_RSR:    v = ((a >> sh) | (a << (w - sh))) & mask;
      OP_MODULE: v = (sa < 0) ? (64'(-sa) & mask) : a;
      OP_MUL: begin
        p = a * b; v = p & mask; o = (p >> w) != 0; lat = w + 2;
      end
      OP_DIV, OP_MOD: begin
        if (b == 0) begin v = mask; o = 1; end
        else begin v = (op == OP_DIV) ? a / b : a % b; lat = w + 2; end
      end
      OP_LOG2: begin
        if (a == 0 || a >= msb) begin v = mask; o = 1; end
        else for (int k = 0; k < w; k++) if (a[k]) v = 64'(k);
      end
      OP_FACTRL: begin
        if (a >= msb || a > FMAX) begin v = mask; o = 1; end
        else begin
          v = 1;
          for (int k = 1; k <= int'(a); k++) begin
            v = v * 64'(k);
            if (v > mask) o = 1;
            v = v & mask;
          end
          lat = 2 + int'(a);
        end
      end
      default: nop = 1;
    endcase
    if (nop) begin
      res = pres; flg = pflg;
    end else begin
      flg = {v == 0, (v & msb) != 0, c, o};
      res = keep ? pres : v;
    end
  endtask

  task automatic drive(input bit big, input logic s, input logic [4:0] op,
                       input logic [63:0] a, b);
    if (big) begin
      start32 = s; opcode32 = op; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start16 = s; opcode16 = op; a16 = a[15:0]; b16 = b[15:0];
    end
  endtask

  task automatic sample(input bit big, output logic bz, output logic dn,
                        output logic [63:0] r, output logic [3:0] f);
    bz = big ? busy32 : busy16;
    dn = big ? done32 : done16;
    r  = big ? 64'(res32) : 64'(res16);
    f  = big ? flags32 : flags16;
  endtask

  // One operation: launch, scramble inputs (optionally holding start high)
  // while busy, then check latency, result, flags and return to idle.
  task automatic run_op(input bit big, input logic [4:0] op, input logic [63:0] a_in,
                        input logic [63:0] b_in, input bit noisy,
                        output logic [63:0] got_res, output logic [3:0] got_flg,
                        output int cyc);
    int w, lat, idx;
    logic [63:0] a, b, er, r;
    logic [3:0] ef, f;
    logic bz, dn;
    idx = big ? 1 : 0;
    w   = big ? 32 : 16;
    a   = a_in & ((64'd1 << w) - 1);
    b   = b_in & ((64'd1 << w) - 1);
    model(w, op, a, b, exp_res[idx], exp_flg[idx], er, ef, lat);
    @(negedge clk);
    drive(big, 1'b1, op, a, b);
    @(negedge clk);
    cyc = 1;
    sample(big, bz, dn, r, f);
    check("busy_on", 64'(bz), 64'd1);
    check("res_hold", r, exp_res[idx]);
    while (!dn && cyc < 100) begin
      drive(big, noisy, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      cyc++;
      sample(big, bz, dn, r, f);
    end
    got_res = r;
    got_flg = f;
    check("latency", 64'(cyc), 64'(lat));
    check("result", r, er);
    check("flags", 64'(f), 64'(ef));
    // start may still be high across the DONE->IDLE edge; it must be ignored
    @(posedge clk);
    #1 drive(big, 1'b0, OP_NOP, 0, 0);
    @(negedge clk);
    sample(big, bz, dn, r, f);
    check("idle_after", 64'({bz, dn}), 64'd0);
    exp_res[idx] = er;
    exp_flg[idx] = ef;
    n_trans++;
    $display("T%0d w=%0d op=%02h a=%0h b=%0h res=%0h flg=%b lat=%0d", n_trans, w, op,
             a, b, got_res, got_flg, cyc);
  endtask

  initial begin
    logic [63:0] r, a, b;
    logic [3:0] f;
    logic [4:0] op;
    int cyc;

    rst = 1'b1;
    drive(0, 0, OP_NOP, 0, 0);
    drive(1, 0, OP_NOP, 0, 0);
    exp_res[0] = 0; exp_flg[0] = 0;
    exp_res[1] = 0; exp_flg[1] = 0;
    repeat (3) @(negedge clk);
    check("rst_out16", {busy16, done16, res16, flags16}, 0);
    check("rst_out32", {busy32, done32, res32, flags32}, 0);
    rst = 1'b0;

    // Directed vectors
    run_op(0, OP_ADD, 64'h7FFF, 64'h0001, 0, r, f, cyc);
    check("add_res", r, 64'h8000);
    check("add_flg", 64'(f), 64'b0101);
    run_op(0, OP_MUL, 64'h0100, 64'h0100, 0, r, f, cyc);
    check("mul_lat", 64'(cyc), 64'd18);
    check("mul_flg", 64'(f), 64'b1001);
    run_op(0, OP_DIV, 100, 7, 0, r, f, cyc);
    check("div_res", r, 64'd14);
    run_op(0, OP_MOD, 100, 7, 0, r, f, cyc);
    check("mod_res", r, 64'd2);
    run_op(0, OP_DIV, 100, 0, 0, r, f, cyc);
    check("div0_res", r, 64'hFFFF);
    check("div0_o", 64'(f[FLAG_O]), 64'd1);
    check("div0_lat", 64'(cyc), 64'd2);
    run_op(0, OP_FACTRL, 5, 0, 1, r, f, cyc);
    check("fact5_res", r, 64'd120);
    check("fact5_lat", 64'(cyc), 64'd7);
    run_op(0, OP_FACTRL, 9, 0, 0, r, f, cyc);
    check("fact9_res", r, 64'hFFFF);
    run_op(0, OP_FACTRL, 0, 0, 0, r, f, cyc);
    run_op(0, OP_FACTRL, 8, 0, 1, r, f, cyc);
    run_op(0, OP_FACTRL, 16'hFFFB, 0, 0, r, f, cyc);
    run_op(0, OP_LOG2, 0, 0, 0, r, f, cyc);
    run_op(0, OP_LOG2, 1, 0, 0, r, f, cyc);
    run_op(0, OP_LOG2, 16'h4001, 0, 0, r, f, cyc);
    run_op(0, OP_LOG2, 16'h8000, 0, 0, r, f, cyc);
    run_op(0, OP_SUB, 16'h8000, 1, 0, r, f, cyc);
    run_op(0, OP_CMP, 3, 5, 0, r, f, cyc);
    run_op(0, OP_TST, 16'hF0F0, 16'h0F0F, 0, r, f, cyc);
    run_op(0, OP_NOP, 1, 2, 1, r, f, cyc);
    run_op(0, OP_RSR, 16'h0001, 17, 0, r, f, cyc);
    run_op(0, OP_MODULE, 16'h8000, 0, 0, r, f, cyc);
    run_op(1, OP_RSL, 64'h80000001, 33, 0, r, f, cyc);
    check("rsl32_res", r, 64'h3);
    check("rsl32_c", 64'(f[FLAG_C]), 64'd0);
    run_op(1, OP_MUL, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, r, f, cyc);
    run_op(1, OP_DIV, 64'hFFFFFFFF, 64'h10, 0, r, f, cyc);

    // Random operations on both widths
    for (int t = 0; t < 90; t++) begin
      op = 5'($urandom_range(0, 22));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if (op == OP_FACTRL && $urandom_range(0, 3) != 0) a = 64'($urandom_range(0, 10));
      if (op == OP_DIV || op == OP_MOD) begin
        if ($urandom_range(0, 5) == 0) b = 0;
        else if ($urandom_range(0, 1) == 0) b = 64'($urandom_range(1, 300));
      end
      if (op == OP_LOG2 && $urandom_range(0, 1) == 0) a = 64'($urandom_range(0, 70));
      run_op(t >= 60, op, a, b, $urandom_range(0, 1) == 1, r, f, cyc);
    end

    // Reset in the middle of a division
    @(negedge clk);
    drive(0, 1'b1, OP_DIV, 64'hFFFF, 3);
    @(negedge clk);
    drive(0, 1'b0, OP_NOP, 0, 0);
    repeat (5) @(negedge clk);
    check("mid_busy", 64'(busy16), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", {busy16, done16, res16, flags16}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_res[0] = 0; exp_flg[0] = 0;
    exp_res[1] = 0; exp_flg[1] = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("no_done", 64'({busy16, done16}), 64'd0);
    end
    run_op(0, OP_ADD, 3, 4, 0, r, f, cyc);
    check("post_rst_add", r, 64'd7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
